avalon_msg_parser: RTL and testbench

- Streaming de-framer. Accepts a 64-bit big-endian Avalon-ST-like payload stream and emits one 256-bit output beat per embedded message.
- Payload layout: a 2-byte message count, then repeated records of 2-byte length followed by that many message bytes.
- Sits between a packet receive MAC/FIFO and downstream message consumers.
- No output backpressure.

---
 rtl/parser_pkg.sv | 34 +++
 rtl/parser_msg_assembler.sv | 70 +++++++
 rtl/avalon_msg_parser.sv | 123 ++++++++++++
 tb/tb_avalon_msg_parser.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared types and constants for the Avalon-ST message de-framer.
// The byte-state enum drives the per-lane header/body walk in the top.
package parser_pkg;

    localparam int IP_DATA_WIDTH = 64;
    localparam int OP_DATA_WIDTH = 256;
    localparam int OP_BM_WIDTH   = OP_DATA_WIDTH / 8;
    localparam int BYTES_IN      = IP_DATA_WIDTH / 8;
    localparam int BYTES_OUT     = OP_BM_WIDTH;

    localparam logic [15:0] MIN_MSG_LEN = 16'd8;
    localparam logic [15:0] MAX_MSG_LEN = 16'd32;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        LEN_HI,
        LEN_LO,
        BODY,
        DROP,
        DRAIN
    } byte_state_e;

    // Low n bits set: the bytemask for a right-aligned n-byte message.
    function automatic logic [BYTES_OUT-1:0] len_to_mask(input logic [5:0] n);
        logic [BYTES_OUT-1:0] m;
        for (int i = 0; i < BYTES_OUT; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/parser_msg_assembler.sv
// 32-byte shift/accumulate buffer with byte counter; registers each completed message.
// PARSER_ZERO_FILL_EN clears the buffer at message start so unmasked output bytes read 0.
module parser_msg_assembler
    import parser_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [IP_DATA_WIDTH-1:0] in_data,
    input  logic [BYTES_IN-1:0]      lane_collect,
    input  logic [BYTES_IN-1:0]      lane_start,
    input  logic [BYTES_IN-1:0]      lane_done,
    output logic                     out_valid,
    output logic [OP_DATA_WIDTH-1:0] out_data,
    output logic [OP_BM_WIDTH-1:0]   out_bytemask
);

    logic [OP_DATA_WIDTH-1:0] acc_q, acc_d;
    logic [5:0]               cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [OP_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [OP_BM_WIDTH-1:0]   out_bytemask_q, out_bytemask_d;

    // Lanes are applied in MSB-first order; a new message can begin in the
    // same beat that an earlier one completes, so the capture happens mid-walk.
    always_comb begin
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        out_valid_d    = 1'b0;
        out_data_d     = out_data_q;
        out_bytemask_d = out_bytemask_q;
        for (int l = 0; l < BYTES_IN; l++) begin
            if (lane_start[l]) begin
                cnt_d = '0;
`ifdef PARSER_ZERO_FILL_EN
                acc_d = '0;
`endif
            end
            if (lane_collect[l]) begin
                acc_d = {acc_d[OP_DATA_WIDTH-9:0], in_data[8*(BYTES_IN-1-l) +: 8]};
                cnt_d = cnt_d + 6'd1;
            end
            if (lane_done[l]) begin
                out_valid_d    = 1'b1;
                out_data_d     = acc_d;
                out_bytemask_d = len_to_mask(cnt_d);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q          <= '0;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_bytemask_q <= '0;
        end else begin
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_bytemask_q <= out_bytemask_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_bytemask = out_bytemask_q;

endmodule

// File: rtl/avalon_msg_parser.sv
// Streaming de-framer: walks up to 8 payload bytes per beat through the header/body
// state machine and emits one right-aligned 256-bit beat per message (PARSER_ZERO_FILL_EN optional).
module avalon_msg_parser
    import parser_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic                     in_startofpayload,
    input  logic                     in_endofpayload,
    input  logic [IP_DATA_WIDTH-1:0] in_data,
    input  logic [2:0]               in_empty,
    input  logic                     in_error,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [OP_DATA_WIDTH-1:0] out_data,
    output logic [OP_BM_WIDTH-1:0]   out_bytemask
);

    byte_state_e         state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         idx_q, idx_d;
    logic                in_ready_q, in_ready_d;
    logic                consume;
    logic [3:0]          n_lanes;
    logic [7:0]          lane_byte;
    logic [BYTES_IN-1:0] lane_collect, lane_start, lane_done;

    assign consume    = in_valid && in_ready_q;
    assign n_lanes    = in_endofpayload ? (4'd8 - {1'b0, in_empty}) : 4'd8;
    assign in_ready_d = 1'b1;

    always_comb begin
        lane_collect = '0;
        lane_start   = '0;
        lane_done    = '0;
        lane_byte    = '0;
        cnt_d        = cnt_q;
        len_d        = len_q;
        idx_d        = idx_q;
        // An SOP beat restarts header parsing at lane 0 regardless of state.
        state_d      = (consume && in_startofpayload) ? CNT_HI : state_q;
        for (int l = 0; l < BYTES_IN; l++) begin
            lane_byte = in_data[8*(BYTES_IN-1-l) +: 8];
            if (consume && (l < int'(n_lanes))) begin
                case (state_d)
                    CNT_HI: begin
                        cnt_d   = {lane_byte, cnt_d[7:0]};
                        state_d = CNT_LO;
                    end
                    CNT_LO: begin
                        cnt_d   = {cnt_d[15:8], lane_byte};
                        state_d = (cnt_d == 16'd0) ? DRAIN : LEN_HI;
                    end
                    LEN_HI: begin
                        len_d   = {lane_byte, len_d[7:0]};
                        state_d = LEN_LO;
                    end
                    LEN_LO: begin
                        len_d = {len_d[15:8], lane_byte};
                        idx_d = 16'd0;
                        if (len_d >= MIN_MSG_LEN && len_d <= MAX_MSG_LEN) begin
                            state_d       = BODY;
                            lane_start[l] = 1'b1;
                        end else if (len_d != 16'd0) begin
                            state_d = DROP;
                        end else begin
                            // Zero-length record has no body bytes to skip.
                            cnt_d   = cnt_d - 16'd1;
                            state_d = (cnt_d == 16'd0) ? DRAIN : LEN_HI;
                        end
                    end
                    BODY, DROP: begin
                        idx_d = idx_d + 16'd1;
                        if (state_d == BODY) lane_collect[l] = 1'b1;
                        if (idx_d == len_d) begin
                            if (state_d == BODY) lane_done[l] = 1'b1;
                            cnt_d   = cnt_d - 16'd1;
                            state_d = (cnt_d == 16'd0) ? DRAIN : LEN_HI;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (consume) begin
            if (in_error)             state_d = in_endofpayload ? IDLE : DRAIN;
            else if (in_endofpayload) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;

    parser_msg_assembler u_assembler (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .lane_collect (lane_collect),
        .lane_start   (lane_start),
        .lane_done    (lane_done),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_bytemask (out_bytemask)
    );

endmodule

// File: tb/tb_avalon_msg_parser.sv
// Directed bench for avalon_msg_parser: payloads are built byte-by-byte, sent as
// 8-lane beats, and every out_valid pulse is captured and compared to hand-derived values.
module tb_avalon_msg_parser;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_startofpayload;
    logic         in_endofpayload;
    logic [63:0]  in_data;
    logic [2:0]   in_empty;
    logic         in_error;
    logic         in_ready;
    logic         out_valid;
    logic [255:0] out_data;
    logic [31:0]  out_bytemask;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int eop_cyc  = 0;

    logic [7:0]   pl[$];
    logic [255:0] pd[$];
    logic [31:0]  pm[$];
    int           pc[$];

    avalon_msg_parser dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_startofpayload (in_startofpayload),
        .in_endofpayload   (in_endofpayload),
        .in_data           (in_data),
        .in_empty          (in_empty),
        .in_error          (in_error),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_bytemask      (out_bytemask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            pd.push_back(out_data);
            pm.push_back(out_bytemask);
            pc.push_back(cyc);
            $display("pulse cyc=%0d mask=%h data=%h", cyc, out_bytemask, out_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rep_fill(input logic [7:0] f, input int n);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = f;
        return r;
    endfunction

    function automatic logic [255:0] keep_masked(input logic [255:0] d, input logic [31:0] m);
        logic [255:0] r;
        r = d;
        for (int i = 0; i < 32; i++) if (!m[i]) r[8*i +: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [63:0] pack_beat(input int k);
        logic [63:0] d;
        d = '0;
        for (int j = 0; j < 8; j++)
            if (8*k + j < pl.size()) d[8*(7-j) +: 8] = pl[8*k + j];
        return d;
    endfunction

    task automatic add_count(input logic [15:0] n);
        pl.push_back(n[15:8]);
        pl.push_back(n[7:0]);
    endtask

    task automatic add_fill(input logic [7:0] f, input int n);
        for (int i = 0; i < n; i++) pl.push_back(f);
    endtask

    task automatic add_msg(input logic [15:0] len, input logic [7:0] f);
        add_count(len);
        add_fill(f, int'(len));
    endtask

    task automatic clear_capture();
        pd.delete();
        pm.delete();
        pc.delete();
    endtask

    task automatic idle(input int n);
        in_valid          = 1'b0;
        in_startofpayload = 1'b0;
        in_endofpayload   = 1'b0;
        in_error          = 1'b0;
        in_empty          = 3'd0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic sop, input logic eop,
                              input logic [2:0] empty, input logic err);
        in_valid          = 1'b1;
        in_startofpayload = sop;
        in_endofpayload   = eop;
        in_data           = d;
        in_empty          = empty;
        in_error          = err;
        @(posedge clk);
        #1;
        $display("beat sop=%0b eop=%0b empty=%0d err=%0b data=%h", sop, eop, empty, err, d);
    endtask

    task automatic send_payload(input int gap_after, input int err_beat);
        int n, nb;
        n  = pl.size();
        nb = (n + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            drive_beat(pack_beat(k), k == 0, k == nb - 1,
                       (k == nb - 1) ? 3'(8*nb - n) : 3'd0, k == err_beat);
            if (k == nb - 1) eop_cyc = cyc;
            if (k == gap_after) idle(1);
        end
        idle(0);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        in_data = '0;
        idle(0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 256'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_bytemask !== 32'd0) begin failures++; $display("FAIL reset_bytemask got=%h exp=0", out_bytemask); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_nominal();
        int         lens[8]  = '{9, 11, 14, 12, 17, 10, 16, 13};
        logic [7:0] fills[8] = '{8'h62, 8'h43, 8'h44, 8'h45, 8'h46, 8'h30, 8'h47, 8'h48};
        logic [31:0] masks[8] = '{32'h1FF, 32'h7FF, 32'h3FFF, 32'hFFF,
                                  32'h1FFFF, 32'h3FF, 32'hFFFF, 32'h1FFF};
        clear_capture();
        pl.delete();
        add_count(16'd8);
        for (int i = 0; i < 8; i++) add_msg(16'(lens[i]), fills[i]);
        add_fill(8'hEE, 4);
        send_payload(7, -1);
        idle(3);
        checks++; if (pm.size() != 8) begin failures++; $display("FAIL nominal_pulses got=%0d exp=8", pm.size()); end
        for (int i = 0; i < 8 && i < pm.size(); i++) begin
            checks++;
            if (pm[i] !== masks[i]) begin
                failures++; $display("FAIL nominal_mask[%0d] got=%h exp=%h", i, pm[i], masks[i]);
            end
            checks++;
            if (keep_masked(pd[i], masks[i]) !== rep_fill(fills[i], lens[i])) begin
                failures++; $display("FAIL nominal_data[%0d] got=%h exp=%h", i, pd[i], rep_fill(fills[i], lens[i]));
            end
        end
    endtask

    task automatic test_max_len();
        clear_capture();
        pl.delete();
        add_count(16'd2);
        add_msg(16'd11, 8'h5B);
        add_msg(16'h0020, 8'hA5);
        send_payload(1, -1);
        idle(3);
        checks++; if (pm.size() != 2) begin failures++; $display("FAIL maxlen_pulses got=%0d exp=2", pm.size()); end
        if (pm.size() == 2) begin
            checks++; if (pm[0] !== 32'h7FF) begin failures++; $display("FAIL maxlen_mask0 got=%h exp=7ff", pm[0]); end
            checks++; if (keep_masked(pd[0], 32'h7FF) !== rep_fill(8'h5B, 11)) begin failures++; $display("FAIL maxlen_data0 got=%h", pd[0]); end
            checks++; if (pm[1] !== 32'hFFFFFFFF) begin failures++; $display("FAIL maxlen_mask1 got=%h exp=ffffffff", pm[1]); end
            checks++; if (pd[1] !== rep_fill(8'hA5, 32)) begin failures++; $display("FAIL maxlen_data1 got=%h exp=%h", pd[1], rep_fill(8'hA5, 32)); end
            checks++; if (pc[1] != eop_cyc) begin failures++; $display("FAIL maxlen_latency got=%0d exp=%0d", pc[1], eop_cyc); end
        end
    endtask

    task automatic test_illegal_len();
        clear_capture();
        pl.delete();
        add_count(16'd3);
        add_msg(16'h0004, 8'h11);
        add_msg(16'h0021, 8'h22);
        add_msg(16'h0008, 8'h33);
        send_payload(-1, -1);
        idle(3);
        checks++; if (pm.size() != 1) begin failures++; $display("FAIL illegal_pulses got=%0d exp=1", pm.size()); end
        if (pm.size() == 1) begin
            checks++; if (pm[0] !== 32'hFF) begin failures++; $display("FAIL illegal_mask got=%h exp=ff", pm[0]); end
            checks++; if (keep_masked(pd[0], 32'hFF) !== rep_fill(8'h33, 8)) begin failures++; $display("FAIL illegal_data got=%h", pd[0]); end
        end
    endtask

    task automatic test_truncated();
        clear_capture();
        pl.delete();
        add_count(16'd2);
        add_count(16'd12);
        add_fill(8'h44, 5);
        send_payload(-1, -1);
        idle(2);
        checks++; if (pm.size() != 0) begin failures++; $display("FAIL trunc_pulses got=%0d exp=0", pm.size()); end
        pl.delete();
        add_count(16'd1);
        add_msg(16'd10, 8'h5A);
        send_payload(-1, -1);
        idle(3);
        checks++; if (pm.size() != 1) begin failures++; $display("FAIL trunc_next_pulses got=%0d exp=1", pm.size()); end
        if (pm.size() == 1) begin
            checks++; if (pm[0] !== 32'h3FF) begin failures++; $display("FAIL trunc_next_mask got=%h exp=3ff", pm[0]); end
            checks++; if (keep_masked(pd[0], 32'h3FF) !== rep_fill(8'h5A, 10)) begin failures++; $display("FAIL trunc_next_data got=%h", pd[0]); end
        end
    endtask

    task automatic test_error();
        clear_capture();
        pl.delete();
        add_count(16'd3);
        add_msg(16'd15, 8'h71);
        add_msg(16'd16, 8'h72);
        add_msg(16'd8, 8'h73);
        send_payload(-1, 3);
        idle(3);
        checks++; if (pm.size() != 1) begin failures++; $display("FAIL error_pulses got=%0d exp=1", pm.size()); end
        if (pm.size() == 1) begin
            checks++; if (pm[0] !== 32'h7FFF) begin failures++; $display("FAIL error_mask got=%h exp=7fff", pm[0]); end
            checks++; if (keep_masked(pd[0], 32'h7FFF) !== rep_fill(8'h71, 15)) begin failures++; $display("FAIL error_data got=%h", pd[0]); end
        end
    endtask

    task automatic test_sop_restart();
        clear_capture();
        pl.delete();
        add_count(16'd2);
        add_msg(16'd20, 8'h10);
        drive_beat(pack_beat(0), 1'b1, 1'b0, 3'd0, 1'b0);
        pl.delete();
        add_count(16'd1);
        add_msg(16'd9, 8'h3C);
        send_payload(-1, -1);
        idle(3);
        checks++; if (pm.size() != 1) begin failures++; $display("FAIL restart_pulses got=%0d exp=1", pm.size()); end
        if (pm.size() == 1) begin
            checks++; if (pm[0] !== 32'h1FF) begin failures++; $display("FAIL restart_mask got=%h exp=1ff", pm[0]); end
            checks++; if (keep_masked(pd[0], 32'h1FF) !== rep_fill(8'h3C, 9)) begin failures++; $display("FAIL restart_data got=%h", pd[0]); end
        end
    endtask

    task automatic test_async_reset();
        clear_capture();
        pl.delete();
        add_count(16'd1);
        add_msg(16'd16, 8'h55);
        drive_beat(pack_beat(0), 1'b1, 1'b0, 3'd0, 1'b0);
        idle(0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 256'd0) begin failures++; $display("FAIL areset_out_data got=%h exp=0", out_data); end
        checks++; if (out_bytemask !== 32'd0) begin failures++; $display("FAIL areset_bytemask got=%h exp=0", out_bytemask); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL areset_in_ready got=%b exp=0", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // Remainder of the interrupted payload arrives without SOP and must be ignored.
        drive_beat(pack_beat(1), 1'b0, 1'b0, 3'd0, 1'b0);
        drive_beat(pack_beat(2), 1'b0, 1'b1, 3'd4, 1'b0);
        idle(2);
        checks++; if (pm.size() != 0) begin failures++; $display("FAIL areset_stale_pulses got=%0d exp=0", pm.size()); end
        pl.delete();
        add_count(16'd1);
        add_msg(16'd8, 8'h99);
        send_payload(-1, -1);
        idle(3);
        checks++; if (pm.size() != 1) begin failures++; $display("FAIL areset_next_pulses got=%0d exp=1", pm.size()); end
        if (pm.size() == 1) begin
            checks++; if (pm[0] !== 32'hFF) begin failures++; $display("FAIL areset_next_mask got=%h exp=ff", pm[0]); end
            checks++; if (keep_masked(pd[0], 32'hFF) !== rep_fill(8'h99, 8)) begin failures++; $display("FAIL areset_next_data got=%h", pd[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_max_len();
        test_illegal_len();
        test_truncated();
        test_error();
        test_sop_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
